hqm_rcfwl_pgcb_clkgate_ctl: RTL

//   Idle-driven clock-gate enable controller for a PGCB-managed domain.

---
 rtl/hqm_rcfwl_pgcb_clkgate_ctl.sv | 106 ++++++++++
 1 files changed

// File: rtl/hqm_rcfwl_pgcb_clkgate_ctl.sv
// Idle-driven clock-gate enable controller: runs the clkreq/clkack handshake,
// inserts a wake settle delay and holds the clock on through an idle hysteresis window.
module hqm_rcfwl_pgcb_clkgate_ctl #(
    parameter int WAKE_DLY = 4,
    parameter int HYST_W   = 8
) (
    input  logic              clk,
    input  logic              clr_b,
    input  logic              clkreq_sync,
    input  logic              busy,
    input  logic              force_on,
    input  logic [HYST_W-1:0] hyst_cnt,
    output logic              gate_en,
    output logic              clkack,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_HYST = 2'd3
    } state_t;

    localparam logic [7:0]        WAKE_LOAD = 8'(WAKE_DLY - 1);
    localparam logic [7:0]        WCNT_ONE  = 8'd1;
    localparam logic [HYST_W-1:0] HCNT_ONE  = HYST_W'(1);
    localparam logic [HYST_W-1:0] HCNT_ZERO = '0;

    state_t            state_reg, state_next;
    logic [7:0]        wcnt_reg, wcnt_next;
    logic [HYST_W-1:0] hcnt_reg, hcnt_next;
    logic              gate_en_reg, gate_en_next;
    logic              clkack_reg, clkack_next;
    logic              act;

    assign act = clkreq_sync | busy | force_on;

    always_ff @(posedge clk or negedge clr_b) begin
        if (!clr_b) begin
            state_reg   <= ST_OFF;
            wcnt_reg    <= '0;
            hcnt_reg    <= '0;
            gate_en_reg <= 1'b0;
            clkack_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            wcnt_reg    <= wcnt_next;
            hcnt_reg    <= hcnt_next;
            gate_en_reg <= gate_en_next;
            clkack_reg  <= clkack_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        wcnt_next  = wcnt_reg;
        hcnt_next  = hcnt_reg;
        case (state_reg)
            ST_OFF: begin
                if (act) begin
                    state_next = ST_WAKE;
                    wcnt_next  = WAKE_LOAD;
                end
            end
            ST_WAKE: begin
                // Settle delay always runs to completion, even if activity vanishes.
                if (wcnt_reg == 8'd0) begin
                    state_next = ST_ON;
                end else begin
                    wcnt_next = wcnt_reg - WCNT_ONE;
                end
            end
            ST_ON: begin
                if (!act) begin
                    state_next = ST_HYST;
                    hcnt_next  = hyst_cnt;
                end
            end
            ST_HYST: begin
                // Activity takes priority over an expiring idle count.
                if (act) begin
                    state_next = ST_ON;
                    hcnt_next  = HCNT_ZERO;
                end else if (hcnt_reg == HCNT_ZERO) begin
                    state_next = ST_OFF;
                end else begin
                    hcnt_next = hcnt_reg - HCNT_ONE;
                end
            end
            default: begin
                state_next = ST_OFF;
            end
        endcase
    end

    always_comb begin
        gate_en_next = (state_next != ST_OFF) | force_on;
        clkack_next  = clkreq_sync & ((state_next == ST_ON) | (state_next == ST_HYST));
    end

    assign gate_en = gate_en_reg;
    assign clkack  = clkack_reg;
    assign state   = state_reg;

endmodule
